i2c_slave_responder: RTL and testbench

- Single-address I2C slave (responder) modelling the TMP101 end of the bus driven by our I2C master controller/data unit.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches the 7-bit address, ACKs, then either returns a 16-bit temperature word (read) or accepts a pointer byte plus data bytes (write).
- Used as an on-board loopback target and as the bench partner for the master.

---
 rtl/i2c_slave_responder.sv | 216 +++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_responder.sv
// Single-address I2C responder (TMP101 model): oversampled SCL/SDA, START/STOP detection,
// address match with ACK, 16-bit temperature read-back, pointer + data byte writes.
module i2c_slave_responder #(
  parameter logic [6:0]  SlaveAddress = 7'b1001000,
  parameter int unsigned SyncStages   = 2
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        SCL,
  inout  wire         SDA,
  input  logic [15:0] TempData,
  output logic [7:0]  PointerReg,
  output logic [7:0]  RxData,
  output logic        RxValid,
  output logic        AddressMatch,
  output logic        Busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_TX_DATA, S_TX_ACK, S_RX_DATA, S_RX_ACK, S_WAIT_STOP
  } state_e;

  logic [SyncStages-1:0] scl_sync_q, sda_sync_q;
  logic                  scl_prev_q, sda_prev_q;
  logic                  scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  state_e                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            shift_q, shift_d;
  logic [7:0]            shift_next, tx_byte;
  logic                  rw_q, rw_d, phase_q, phase_d, byte_sel_q, byte_sel_d, first_q, first_d;
  logic [15:0]           hold_q, hold_d;
  logic                  sda_low_q, sda_low_d;
  logic [7:0]            pointer_q, pointer_d, rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d, match_q, match_d, busy_q, busy_d;
  logic                  last_bit;

  assign SDA          = sda_low_q ? 1'b0 : 1'bz;
  assign PointerReg   = pointer_q;
  assign RxData       = rx_data_q;
  assign RxValid      = rx_valid_q;
  assign AddressMatch = match_q;
  assign Busy         = busy_q;

  // Bus lines idle high, so synchronisers reset to 1 to avoid a false START after reset
  always_ff @(posedge clock) begin
    if (Reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SyncStages-2:0], SCL};
      sda_sync_q <= {sda_sync_q[SyncStages-2:0], SDA};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SyncStages-1];
  assign sda_s      = sda_sync_q[SyncStages-1];
  assign scl_rise   = scl_s & ~scl_prev_q;
  assign scl_fall   = ~scl_s & scl_prev_q;
  // SCL must be stable high across both samples, so a simultaneous toggle is a data edge
  assign start_det  = ~sda_s & sda_prev_q & scl_s & scl_prev_q;
  assign stop_det   = sda_s & ~sda_prev_q & scl_s & scl_prev_q;
  assign shift_next = {shift_q, sda_s};
  assign tx_byte    = byte_sel_q ? hold_q[7:0] : hold_q[15:8];
  assign last_bit   = (bit_cnt_q == 3'd7);

  always_ff @(posedge clock) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = S_ADDR;
    end else if (stop_det) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_ADDR:     if (scl_rise && last_bit)
                      state_d = (shift_next[7:1] == SlaveAddress) ? S_ADDR_ACK : S_WAIT_STOP;
        S_ADDR_ACK: if (scl_fall && phase_q) state_d = rw_q ? S_TX_DATA : S_RX_DATA;
        S_TX_DATA:  if (scl_fall && last_bit) state_d = S_TX_ACK;
        S_TX_ACK: begin
          if (scl_rise && sda_s)         state_d = S_WAIT_STOP;
          else if (scl_fall && phase_q)  state_d = S_TX_DATA;
        end
        S_RX_DATA:  if (scl_rise && last_bit) state_d = S_RX_ACK;
        S_RX_ACK:   if (scl_fall && phase_q) state_d = S_RX_DATA;
        default:    state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    phase_d    = phase_q;
    byte_sel_d = byte_sel_q;
    first_d    = first_q;
    hold_d     = hold_q;
    sda_low_d  = sda_low_q;
    pointer_d  = pointer_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    match_d    = match_q;
    busy_d     = busy_q;
    if (start_det || stop_det) begin
      bit_cnt_d = 3'd0;
      phase_d   = 1'b0;
      sda_low_d = 1'b0;
      match_d   = 1'b0;
      busy_d    = start_det;
    end else begin
      unique case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d   = shift_next[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          phase_d   = 1'b0;
          if (last_bit) rw_d = sda_s;
        end
        // First falling edge starts the ACK (and captures the read word), second ends it
        S_ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_low_d  = 1'b1;
            match_d    = 1'b1;
            phase_d    = 1'b1;
            byte_sel_d = 1'b0;
            if (rw_q) hold_d = TempData;
          end else begin
            phase_d   = 1'b0;
            bit_cnt_d = 3'd0;
            first_d   = 1'b1;
            sda_low_d = rw_q ? ~hold_q[15] : 1'b0;
          end
        end
        S_TX_DATA: if (scl_fall) begin
          if (last_bit) begin
            sda_low_d = 1'b0;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            sda_low_d = ~tx_byte[3'(3'd6 - bit_cnt_q)];
          end
        end
        S_TX_ACK: begin
          if (scl_rise && !sda_s) begin
            byte_sel_d = ~byte_sel_q;
            phase_d    = 1'b1;
          end else if (scl_fall && phase_q) begin
            sda_low_d = ~tx_byte[7];
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
          end
        end
        S_RX_DATA: if (scl_rise) begin
          shift_d   = shift_next[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          phase_d   = 1'b0;
          if (last_bit) begin
            if (first_q) begin
              pointer_d = shift_next;
              first_d   = 1'b0;
            end else begin
              rx_data_d  = shift_next;
              rx_valid_d = 1'b1;
            end
          end
        end
        S_RX_ACK: if (scl_fall) begin
          sda_low_d = ~phase_q;
          phase_d   = ~phase_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      byte_sel_q <= 1'b0;
      first_q    <= 1'b0;
      hold_q     <= 16'd0;
      sda_low_q  <= 1'b0;
      pointer_q  <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      match_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      byte_sel_q <= byte_sel_d;
      first_q    <= first_d;
      hold_q     <= hold_d;
      sda_low_q  <= sda_low_d;
      pointer_q  <= pointer_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      match_q    <= match_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bit-banged I2C master drives directed and random
// transactions; expected bytes and register values come from a transaction-level model.
module tb_i2c_slave_responder;

  localparam logic [6:0] SlaveAddr = 7'b1001000;
  localparam int         Q         = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_scl;
  logic        m_sda_low;
  logic [15:0] temp;
  wire         sda;
  wire  [7:0]  ptr, rxd;
  wire         rxv, am, busy;

  int vectors     = 0;
  int miscompares = 0;
  int valid_cnt   = 0;

  logic [7:0] model_ptr = 8'h00;
  logic [7:0] model_rx  = 8'h00;
  logic [7:0] wq[$];

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  always @(posedge clk) if (rxv === 1'b1) valid_cnt <= valid_cnt + 1;

  i2c_slave_responder #(.SlaveAddress(SlaveAddr), .SyncStages(2)) dut (
    .clock(clk), .Reset(rst), .SCL(m_scl), .SDA(sda), .TempData(temp),
    .PointerReg(ptr), .RxData(rxd), .RxValid(rxv), .AddressMatch(am), .Busy(busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period starting and ending with SCL low; SDA sampled mid-high
  task automatic bit_cycle(input logic drive_low, output logic sampled);
    clks(Q); m_sda_low = drive_low;
    clks(Q); m_scl = 1'b1;
    clks(Q); sampled = sda;
    clks(Q); m_scl = 1'b0;
  endtask

  task automatic start_cond();
    clks(Q); m_sda_low = 1'b1;
    clks(Q); m_scl = 1'b0;
  endtask

  task automatic rstart_cond();
    clks(Q); m_sda_low = 1'b0;
    clks(Q); m_scl = 1'b1;
    clks(Q); m_sda_low = 1'b1;
    clks(Q); m_scl = 1'b0;
  endtask

  task automatic stop_cond();
    clks(Q); m_sda_low = 1'b1;
    clks(Q); m_scl = 1'b1;
    clks(Q); m_sda_low = 1'b0;
    clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(~b[i], s);
    bit_cycle(1'b0, ack);
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b0, s);
      b[i] = s;
    end
    bit_cycle(master_ack, s);
  endtask

  // Writes pointer + data bytes from wq; model: first byte -> pointer, last later byte -> RxData
  task automatic write_txn(input logic do_stop);
    logic ack;
    int   base;
    base = valid_cnt;
    start_cond();
    check("start busy", 16'(busy), 16'h1);
    send_byte({SlaveAddr, 1'b0}, ack);
    check("wr addr ack", 16'(ack), 16'h0);
    check("wr match", 16'(am), 16'h1);
    foreach (wq[i]) begin
      send_byte(wq[i], ack);
      check("wr data ack", 16'(ack), 16'h0);
    end
    model_ptr = wq[0];
    if (wq.size() > 1) model_rx = wq[wq.size()-1];
    check("wr pointer", 16'(ptr), 16'(model_ptr));
    check("wr rxdata", 16'(rxd), 16'(model_rx));
    check("wr rxvalid pulses", 16'(valid_cnt - base), 16'(wq.size() - 1));
    if (do_stop) begin
      stop_cond();
      check("wr stop busy", 16'(busy), 16'h0);
      check("wr stop match", 16'(am), 16'h0);
    end
  endtask

  // Reads n bytes; expected byte k alternates high/low half of TempData seen at address time
  task automatic read_txn(input int n, input logic repeated, input logic chg, input logic [15:0] newt);
    logic        ack;
    logic [7:0]  b;
    logic [15:0] cap;
    if (repeated) rstart_cond(); else start_cond();
    cap = temp;
    send_byte({SlaveAddr, 1'b1}, ack);
    check("rd addr ack", 16'(ack), 16'h0);
    check("rd match", 16'(am), 16'h1);
    for (int k = 0; k < n; k++) begin
      recv_byte(k < n - 1, b);
      check("rd byte", 16'(b), (k % 2 == 0) ? 16'(cap >> 8) : 16'(cap & 16'h00FF));
      if (chg && k == 0) temp = newt;
    end
    check("rd match before stop", 16'(am), 16'h1);
    stop_cond();
    check("rd stop busy", 16'(busy), 16'h0);
    check("rd stop match", 16'(am), 16'h0);
  endtask

  task automatic mismatch_txn(input logic [7:0] first);
    logic       ack;
    logic [7:0] b;
    start_cond();
    send_byte(first, ack);
    check("mm nack", 16'(ack), 16'h1);
    check("mm match", 16'(am), 16'h0);
    recv_byte(1'b0, b);
    check("mm released", 16'(b), 16'h00FF);
    check("mm busy", 16'(busy), 16'h1);
    stop_cond();
    check("mm stop busy", 16'(busy), 16'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  a7;
    logic        ack;
    int          nb;
    rst = 1'b1; m_scl = 1'b1; m_sda_low = 1'b0; temp = 16'h0000;
    clks(5);
    check("reset sda", 16'(sda), 16'h1);
    check("reset pointer", 16'(ptr), 16'h0);
    check("reset rxdata", 16'(rxd), 16'h0);
    check("reset rxvalid", 16'(rxv), 16'h0);
    check("reset match", 16'(am), 16'h0);
    check("reset busy", 16'(busy), 16'h0);
    rst = 1'b0;
    clks(5);

    temp = 16'h1A30;
    read_txn(2, 1'b0, 1'b0, 16'h0);
    mismatch_txn(8'b10010101);

    wq = '{8'h01, 8'h60};
    write_txn(1'b1);

    temp = 16'h1A30;
    read_txn(3, 1'b0, 1'b1, 16'h2B40);

    wq = '{8'h00};
    write_txn(1'b0);
    temp = 16'($urandom);
    read_txn(2, 1'b1, 1'b0, 16'h0);
    check("rs pointer kept", 16'(ptr), 16'h0000);

    for (int it = 0; it < 3; it++) begin
      wq.delete();
      nb = int'($urandom_range(1, 4));
      for (int j = 0; j < nb; j++) wq.push_back(8'($urandom));
      write_txn(1'b1);
      temp = 16'($urandom);
      read_txn(int'($urandom_range(1, 3)), 1'b0, 1'($urandom), 16'($urandom));
      a7 = 7'($urandom);
      if (a7 == SlaveAddr) a7 = a7 ^ 7'h04;
      mismatch_txn({a7, 1'($urandom)});
    end

    // Reset while the slave is holding SDA low for bit 7 of a zero read word
    temp = 16'h0000;
    start_cond();
    send_byte({SlaveAddr, 1'b1}, ack);
    check("rst addr ack", 16'(ack), 16'h0);
    clks(Q);
    check("rst tx drives low", 16'(sda), 16'h0);
    rst = 1'b1;
    clks(1);
    check("rst sda released", 16'(sda), 16'h1);
    check("rst pointer", 16'(ptr), 16'h0);
    check("rst rxdata", 16'(rxd), 16'h0);
    check("rst rxvalid", 16'(rxv), 16'h0);
    check("rst match", 16'(am), 16'h0);
    check("rst busy", 16'(busy), 16'h0);
    rst = 1'b0;
    model_ptr = 8'h00;
    model_rx  = 8'h00;
    stop_cond();
    temp = 16'hC3A5;
    read_txn(2, 1'b0, 1'b0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
